// File: rtl/axi4_regbank_pkg.sv
// axi4_regbank_pkg: burst/response encodings, FSM states and response merge for the burst register bank
package axi4_regbank_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a == RESP_DECERR || b == RESP_DECERR) ? RESP_DECERR :
               (a == RESP_SLVERR || b == RESP_SLVERR) ? RESP_SLVERR :
               (a == RESP_EXOKAY || b == RESP_EXOKAY) ? RESP_EXOKAY : RESP_OKAY;
    endfunction
endpackage

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: next beat address, word index, decode and protocol-error check; WRAP gated by AXI4_REGBANK_WRAP_EN
module axi4_burst_addr_gen
    import axi4_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [7:0]               len,
    input  logic [2:0]               size,
    input  logic [1:0]               burst,
    output logic [ADDR_WIDTH-1:0]    next_addr,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     in_range,
    output logic                     proto_err
);
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int OFF_LSB = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * BYTES);

    logic [ADDR_WIDTH-1:0] step, incr, wmask, off;

    // Beat stepping: WRAP keeps the upper bits of the aligned window and wraps the lower ones
    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        incr      = addr + step;
        wmask     = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        next_addr = (burst == BURST_FIXED) ? addr :
                    (burst == BURST_INCR)  ? incr : ((addr & ~wmask) | (incr & wmask));
        off       = addr - BASE_ADDR;
        in_range  = (addr >= BASE_ADDR) && (off < SPAN);
        idx       = $clog2(DEPTH)'(off >> OFF_LSB);
    end

`ifdef AXI4_REGBANK_WRAP_EN
    logic wrap_err;

    // Oversize beats, reserved burst type and malformed WRAP bursts are rejected
    always_comb begin
        wrap_err  = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) ||
                    ((addr & (step - ADDR_WIDTH'(1))) != '0);
        proto_err = (size > 3'(OFF_LSB)) || (burst == 2'b11) || (burst == BURST_WRAP && wrap_err);
    end
`else
    // Oversize beats, reserved burst type and every WRAP burst are rejected
    always_comb begin
        proto_err = (size > 3'(OFF_LSB)) || (burst == 2'b11) || (burst == BURST_WRAP);
    end
`endif
endmodule

// File: rtl/axi4_burst_regbank.sv
// axi4_burst_regbank: AXI4 burst slave register bank with independent write/read FSMs; WRAP enabled by AXI4_REGBANK_WRAP_EN
module axi4_burst_regbank
    import axi4_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    DEPTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWLOCK,
    input  logic [3:0]              AWCACHE,
    input  logic [2:0]              AWPROT,
    input  logic [3:0]              AWQOS,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARLOCK,
    input  logic [3:0]              ARCACHE,
    input  logic [2:0]              ARPROT,
    input  logic [3:0]              ARQOS,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IW    = $clog2(DEPTH);

    logic unused_sideband;
    assign unused_sideband = &{1'b0, AWLOCK, AWCACHE, AWPROT, AWQOS, ARLOCK, ARCACHE, ARPROT, ARQOS};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d, w_beat_resp;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, w_next;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [IW-1:0]         w_idx;
    logic                  w_in, w_err, w_last, we;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, r_beat_data;
    logic [1:0]            rresp_q, rresp_d, r_beat_resp;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, ra_addr, r_next;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d, ra_len;
    logic [2:0]            rsize_q, rsize_d, ra_size;
    logic [1:0]            rburst_q, rburst_d, ra_burst;
    logic [IW-1:0]         r_idx;
    logic                  r_in, r_err;

    axi4_burst_addr_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wgen (
        .addr(waddr_q), .len(wlen_q), .size(wsize_q), .burst(wburst_q),
        .next_addr(w_next), .idx(w_idx), .in_range(w_in), .proto_err(w_err)
    );

    // The read beat presented right after AR must be decoded from the AR inputs themselves
    assign ra_addr  = (r_state_q == R_IDLE) ? ARADDR  : raddr_q;
    assign ra_len   = (r_state_q == R_IDLE) ? ARLEN   : rlen_q;
    assign ra_size  = (r_state_q == R_IDLE) ? ARSIZE  : rsize_q;
    assign ra_burst = (r_state_q == R_IDLE) ? ARBURST : rburst_q;

    axi4_burst_addr_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rgen (
        .addr(ra_addr), .len(ra_len), .size(ra_size), .burst(ra_burst),
        .next_addr(r_next), .idx(r_idx), .in_range(r_in), .proto_err(r_err)
    );

    // Write FSM next state: accept AW, consume exactly AWLEN+1 beats, then hold B until accepted
    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        wcnt_d      = wcnt_q;
        we          = 1'b0;
        w_last      = (wcnt_q == wlen_q);
        w_beat_resp = w_err ? RESP_SLVERR : !w_in ? RESP_DECERR : RESP_OKAY;
        if (w_state_q == W_IDLE) begin
            awready_d = 1'b1;
            if (awready_q && AWVALID) begin
                w_state_d = W_DATA;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                bid_d     = AWID;
                bresp_d   = RESP_OKAY;
                waddr_d   = AWADDR;
                wlen_d    = AWLEN;
                wsize_d   = AWSIZE;
                wburst_d  = AWBURST;
                wcnt_d    = 8'd0;
            end
        end else if (w_state_q == W_DATA) begin
            if (wready_q && WVALID) begin
                we      = !w_err && w_in;
                bresp_d = resp_max(bresp_q, resp_max(w_beat_resp, (WLAST != w_last) ? RESP_SLVERR : RESP_OKAY));
                waddr_d = w_next;
                wcnt_d  = wcnt_q + 8'd1;
                if (w_last) begin
                    w_state_d = W_RESP;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                end
            end
        end else if (bvalid_q && BREADY) begin
            w_state_d = W_IDLE;
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
        end
    end

    // Write FSM state and registered write-channel outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Register bank with per-byte strobed writes
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < BYTES; b++) if (WSTRB[b]) mem_q[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
        end
    end

    // Read FSM next state: load beat 0 on AR, then load the following beat on each R handshake
    always_comb begin
        r_state_d   = r_state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        raddr_d     = raddr_q;
        rlen_d      = rlen_q;
        rsize_d     = rsize_q;
        rburst_d    = rburst_q;
        rcnt_d      = rcnt_q;
        r_beat_data = (r_err || !r_in) ? '0 : mem_q[r_idx];
        r_beat_resp = r_err ? RESP_SLVERR : !r_in ? RESP_DECERR : RESP_OKAY;
        if (r_state_q == R_IDLE) begin
            arready_d = 1'b1;
            if (arready_q && ARVALID) begin
                r_state_d = R_DATA;
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
                rid_d     = ARID;
                rlen_d    = ARLEN;
                rsize_d   = ARSIZE;
                rburst_d  = ARBURST;
                raddr_d   = r_next;
                rcnt_d    = 8'd0;
                rdata_d   = r_beat_data;
                rresp_d   = r_beat_resp;
                rlast_d   = (ARLEN == 8'd0);
            end
        end else if (rvalid_q && RREADY) begin
            if (rlast_q) begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                arready_d = 1'b1;
            end else begin
                raddr_d = r_next;
                rcnt_d  = rcnt_q + 8'd1;
                rdata_d = r_beat_data;
                rresp_d = r_beat_resp;
                rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            end
        end
    end

    // Read FSM state and registered read-channel outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
endmodule
